uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a circular receive FIFO.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (4..65535)
//   FIFO_DEPTH   : receive FIFO entries, power of two (2..256)
//
// Ports
//   clk         : single clock for all logic
//   rst_n       : asynchronous active-low reset
//   uart_rx     : asynchronous serial line, idle high
//   rx_data     : FIFO head byte, valid while rx_valid=1 (8'h00 when empty)
//   rx_valid    : FIFO not empty
//   rx_ready    : consumer accepts; pop when rx_valid && rx_ready
//   fifo_level  : current FIFO occupancy
//   framing_err : one-cycle pulse on a bad stop bit
//   overrun     : sticky, set when a received byte is dropped on a full FIFO
//   clr_err     : synchronous clear of overrun (a same-cycle drop wins)
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         uart_rx,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         framing_err,
  output logic                         overrun,
  input  logic                         clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  // Synchronizer
  logic rx_meta_q, rxs_q;

  // Receiver
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        timer_zero;
  logic        byte_done;
  logic        frame_bad;

  // FIFO
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        framing_err_q, framing_err_d;
  logic        overrun_q, overrun_d;
  logic        full, empty, pop, push_ok, drop;

  // Two-flop synchronizer; both flops idle high so reset does not look
  // like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign timer_zero = (timer_q == '0);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          timer_d = HALF_BIT;
        end
      end
      START: begin
        // Re-check the line mid start bit to reject short glitches.
        if (timer_zero) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            timer_d   = FULL_BIT;
            bit_idx_d = 3'd0;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_zero) begin
          shift_d = {rxs_q, shift_q[7:1]};
          timer_d = FULL_BIT;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_zero) begin
          state_d = rxs_q ? IDLE : WAIT_HIGH;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      WAIT_HIGH: begin
        // Hold here through a break so it reports a single framing error.
        if (rxs_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    byte_done = 1'b0;
    frame_bad = 1'b0;
    if (state_q == STOP && timer_zero) begin
      byte_done = rxs_q;
      frame_bad = !rxs_q;
    end
  end

  // FIFO control. Pointers carry one extra bit so full and empty differ
  // only in the MSB.
  always_comb begin
    empty         = (wr_ptr_q == rd_ptr_q);
    full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop           = !empty && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok       = byte_done && (!full || pop);
    drop          = byte_done && full && !pop;
    wr_ptr_d      = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    framing_err_d = frame_bad;
    overrun_d     = overrun_q;
    if (clr_err) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  // Storage is not reset; rx_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  assign rx_valid    = !empty;
  assign rx_data     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level  = wr_ptr_q - rd_ptr_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLKS_PER_BIT=8, FIFO_DEPTH=4).
// A queue holds the bytes the line carried with a good stop bit; the
// monitor pops it whenever the consumer takes a byte.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] fifo_level;
  logic       framing_err;
  logic       overrun;
  logic       clr_err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int ferr_exp = 0;
  int n_rcv = 0;
  int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
  logic ovr_exp = 1'b0;
  logic [7:0] q_exp[$];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level),
    .framing_err(framing_err), .overrun(overrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer handshake changes just after the active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: count framing pulses, score every pop against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (framing_err) ferr_cnt++;
      if (rx_valid && rx_ready) begin
        if (q_exp.size() == 0) begin
          chk("pop_with_model_empty", 32'(q_exp.size()), 32'd1);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(q_exp.pop_front()));
          n_rcv++;
        end
      end
    end
  end

  task automatic wait_bits(input int nbits);
    repeat (nbits * CPB) @(negedge clk);
  endtask

  // Sends one 8N1 frame starting at a negedge, followed by one idle bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_bits(1);
    end
    if (stop_ok) begin
      if (q_exp.size() < DEPTH) q_exp.push_back(b);
      else ovr_exp = 1'b1;
    end else begin
      ferr_exp++;
    end
    uart_rx = stop_ok;
    wait_bits(1);
    uart_rx = 1'b1;
    wait_bits(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_ferr"}, 32'(framing_err), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic drain(input string tag);
    rdy_mode = 1;
    for (int i = 0; i < 200 && (rx_valid || q_exp.size() != 0); i++) @(negedge clk);
    chk({tag, "_model_left"}, 32'(q_exp.size()), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    wait_bits(2);

    // Single clean byte
    rdy_mode = 1;
    send_byte(8'hA5, 1'b1);
    drain("a5");
    chk("a5_rcv", 32'(n_rcv), 32'd1);
    chk("a5_ferr", 32'(ferr_cnt), 32'(ferr_exp));
    chk("a5_overrun", 32'(overrun), 32'(ovr_exp));

    // Three-cycle low glitch must be ignored
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    wait_bits(3);
    chk("glitch_ferr", 32'(ferr_cnt), 32'(ferr_exp));
    chk("glitch_level", 32'(fifo_level), 32'd0);
    send_byte(8'h5A, 1'b1);
    drain("post_glitch");
    chk("post_glitch_rcv", 32'(n_rcv), 32'd2);

    // Bad stop bit, then a good frame
    send_byte(8'h3C, 1'b0);
    chk("bad_stop_ferr", 32'(ferr_cnt), 32'(ferr_exp));
    chk("bad_stop_level", 32'(fifo_level), 32'd0);
    send_byte(8'h55, 1'b1);
    drain("post_bad_stop");
    chk("post_bad_stop_rcv", 32'(n_rcv), 32'd3);

    // Overrun on a full FIFO
    rdy_mode = 0;
    wait_bits(1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    chk("ovr_level", 32'(fifo_level), 32'(DEPTH));
    chk("ovr_flag", 32'(overrun), 32'(ovr_exp));
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    drain("ovr_drain");
    chk("ovr_rcv", 32'(n_rcv), 32'd7);
    chk("ovr_sticky", 32'(overrun), 32'(ovr_exp));
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    ovr_exp = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'(ovr_exp));

    // Break: 30 bit times low gives one framing error
    uart_rx = 1'b0;
    wait_bits(30);
    ferr_exp++;
    uart_rx = 1'b1;
    wait_bits(2);
    chk("break_ferr", 32'(ferr_cnt), 32'(ferr_exp));
    chk("break_level", 32'(fifo_level), 32'd0);
    send_byte(8'h96, 1'b1);
    drain("post_break");
    chk("post_break_rcv", 32'(n_rcv), 32'd8);

    // Reset during data bit 4 abandons the frame
    uart_rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      uart_rx = ~uart_rx;
      wait_bits(1);
    end
    uart_rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midframe_reset");
    uart_rx = 1'b1;
    wait_bits(2);
    chk_reset_outputs("midframe_reset_hold");
    rst_n = 1'b1;
    wait_bits(2);
    send_byte(8'h81, 1'b1);
    drain("post_reset");
    chk("post_reset_rcv", 32'(n_rcv), 32'd9);
    chk("post_reset_ferr", 32'(ferr_cnt), 32'(ferr_exp));

    // Randomized frames with a random consumer and occasional bad stops
    rdy_mode = 2;
    for (int k = 0; k < 24; k++) begin
      send_byte(8'($urandom), ($urandom_range(0, 5) != 0));
      wait_bits($urandom_range(0, 2));
    end
    drain("random");
    chk("random_ferr", 32'(ferr_cnt), 32'(ferr_exp));
    chk("random_overrun", 32'(overrun), 32'(ovr_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
